gpio_in_debounce: RTL and testbench

- Conditions the slide-switch bank before it enters the CPU GPIO input port. The block sits upstream of the multi-cycle MIPS core's GPIO_i and runs on the 50 MHz master clock.
- Per bit, it synchronises the raw level, debounces it with a stable-time counter, and outputs a clean level plus one-cycle rise/fall pulses.
- The debounced level is static for milliseconds, so the slow CPU clock samples it safely.

---
 rtl/gpio_in_debounce_pkg.sv | 6 +
 rtl/gpio_in_debounce_if.sv | 16 +
 rtl/debounce_bit.sv | 63 ++++++
 rtl/gpio_in_debounce.sv | 39 +++
 tb/tb_gpio_in_debounce.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_in_debounce_pkg.sv
// gpio_in_debounce_pkg: shared per-bit state encoding and default timing for the switch debouncer
package gpio_in_debounce_pkg;
    typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} deb_state_e;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CYCLES = 500000;
endpackage

// File: rtl/gpio_in_debounce_if.sv
// gpio_in_debounce_if: switch-bank bus into the debouncer; GPIO_STICKY_EVENT_EN adds evt_clr_i/evt_o
interface gpio_in_debounce_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] raw_i;
    logic [WIDTH-1:0] sw_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
`ifdef GPIO_STICKY_EVENT_EN
    logic [WIDTH-1:0] evt_clr_i;
    logic [WIDTH-1:0] evt_o;
    modport master (output raw_i, evt_clr_i, input sw_o, rise_o, fall_o, evt_o);
    modport slave (input raw_i, evt_clr_i, output sw_o, rise_o, fall_o, evt_o);
`else
    modport master (output raw_i, input sw_o, rise_o, fall_o);
    modport slave (input raw_i, output sw_o, rise_o, fall_o);
`endif
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: synchroniser, stable-time counter and commit pulses for one switch input
module debounce_bit
    import gpio_in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sw,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic s;
    deb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sw_d, rise_d, fall_d;
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            sw      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw      <= sw_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end
    // Any sample agreeing with the committed level is a glitch and restarts the stable-time count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == sw) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else if (state_q == ST_STABLE) begin
            state_d = ST_PENDING;
            cnt_d   = CW'(1);
        end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            sw_d    = s;
            rise_d  = s;
            fall_d  = !s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: debounced switch bank with rise/fall pulses; GPIO_STICKY_EVENT_EN adds sticky change flags
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input logic clk,
    input logic reset,
    gpio_in_debounce_if.slave gpio
);
    logic [WIDTH-1:0] sw, rise, fall;
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk(clk),
            .reset(reset),
            .raw(gpio.raw_i[g]),
            .sw(sw[g]),
            .rise(rise[g]),
            .fall(fall[g])
        );
    end
    assign gpio.sw_o = sw;
    assign gpio.rise_o = rise;
    assign gpio.fall_o = fall;
`ifdef GPIO_STICKY_EVENT_EN
    logic [WIDTH-1:0] evt_q;
    // Flags latch from the registered pulses; a commit beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) evt_q <= '0;
        else evt_q <= (evt_q & ~gpio.evt_clr_i) | rise | fall;
    end
    assign gpio.evt_o = evt_q;
`endif
endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: random and directed stimulus against a sliding-window reference of the debouncer
module tb_gpio_in_debounce;
    localparam int W = 8;
    localparam int SS = 2;
    localparam int SC = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] clr_v = '0;
    logic [W-1:0] dl [SS];
    logic [W-1:0] win [SC];
    logic [W-1:0] m_sw, m_rise, m_fall, m_evt;

    gpio_in_debounce_if #(.WIDTH(W)) gpio ();
    gpio_in_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk(clk),
        .reset(reset),
        .gpio(gpio)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) dl[i] = '0;
        for (int i = 0; i < SC; i++) win[i] = '0;
        m_sw = '0; m_rise = '0; m_fall = '0; m_evt = '0;
    endtask

    // A bit commits when its last SC synchronised samples all disagree with the committed level
    task automatic model_step(input logic [W-1:0] r);
        logic [W-1:0] s;
        bit diff;
        m_evt = (m_evt & ~clr_v) | m_rise | m_fall;
        s = dl[SS-1];
        for (int i = SS - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = r;
        for (int i = SC - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = s;
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < W; b++) begin
            diff = 1'b1;
            for (int k = 0; k < SC; k++) if (win[k][b] == m_sw[b]) diff = 1'b0;
            if (diff) begin
                m_rise[b] = s[b];
                m_fall[b] = !s[b];
                m_sw[b] = s[b];
            end
        end
    endtask

    task automatic cycle(input logic [W-1:0] r);
        @(negedge clk);
        gpio.raw_i = r;
`ifdef GPIO_STICKY_EVENT_EN
        gpio.evt_clr_i = clr_v;
`endif
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        gpio.raw_i = '0;
        clr_v = '0;
        model_reset();
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_init got %h exp 000000", {gpio.sw_o, gpio.rise_o, gpio.fall_o});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle(8'h00);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'h0) begin
                n_err++;
                $display("FAIL idle k=%0d got %h exp 000000", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o});
            end
        end
        for (int k = 0; k < SS + SC; k++) cycle(8'hff);
        n_cmp++;
        if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'hffff00) begin
            n_err++;
            $display("FAIL pre_reset got %h exp ffff00", {gpio.sw_o, gpio.rise_o, gpio.fall_o});
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'h0) begin
            n_err++;
            $display("FAIL async_reset got %h exp 000000", {gpio.sw_o, gpio.rise_o, gpio.fall_o});
        end
        model_reset();
        #1 reset = 1'b1;
    endtask

    task automatic test_rise_step();
        int first = -1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(8'h01);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== {m_sw, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL rise_step k=%0d got %h exp %h", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o}, {m_sw, m_rise, m_fall});
            end
            if (gpio.rise_o[0] && first < 0) first = k;
        end
        n_cmp++;
        if (first != SS + SC - 1) begin
            n_err++;
            $display("FAIL rise_latency got %0d exp %0d", first, SS + SC - 1);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < 13; k++) begin
            cycle(k < 3 ? 8'h08 : 8'h00);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'h0) begin
                n_err++;
                $display("FAIL glitch k=%0d got %h exp 000000", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o});
            end
        end
        for (int k = 0; k < SC + SS; k++) cycle(8'h08);
        n_cmp++;
        if (gpio.rise_o !== 8'h08) begin
            n_err++;
            $display("FAIL glitch_recount got rise %h exp 08", gpio.rise_o);
        end
    endtask

    task automatic test_multi();
        int falls = 0;
        int at = -1;
        do_reset();
        for (int k = 0; k < 8; k++) cycle(8'hff);
        for (int k = 0; k < 10; k++) begin
            cycle(8'h0f);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== {m_sw, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL multi k=%0d got %h exp %h", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o}, {m_sw, m_rise, m_fall});
            end
            if (gpio.fall_o != 0) begin
                falls++;
                at = k;
                n_cmp++;
                if (gpio.fall_o !== 8'hf0) begin
                    n_err++;
                    $display("FAIL multi_fall got %h exp f0", gpio.fall_o);
                end
            end
        end
        n_cmp++;
        if (falls != 1 || at != SS + SC - 1 || gpio.sw_o !== 8'h0f) begin
            n_err++;
            $display("FAIL multi_once got cycles=%0d at=%0d sw=%h exp 1/%0d/0f", falls, at, gpio.sw_o, SS + SC - 1);
        end
    endtask

    task automatic test_reset_pending();
        int first = -1;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(8'h20);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== 24'h0) begin
            n_err++;
            $display("FAIL pending_reset got %h exp 000000", {gpio.sw_o, gpio.rise_o, gpio.fall_o});
        end
        model_reset();
        #1 reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle(8'h20);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== {m_sw, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL pending k=%0d got %h exp %h", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o}, {m_sw, m_rise, m_fall});
            end
            if (gpio.sw_o[5] && first < 0) first = k;
        end
        n_cmp++;
        if (first != SS + SC - 1) begin
            n_err++;
            $display("FAIL pending_latency got %0d exp %0d", first, SS + SC - 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r = '0;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) r ^= W'($urandom);
`ifdef GPIO_STICKY_EVENT_EN
            clr_v = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
`endif
            cycle(r);
            n_cmp++;
            if ({gpio.sw_o, gpio.rise_o, gpio.fall_o} !== {m_sw, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL random k=%0d got %h exp %h", k, {gpio.sw_o, gpio.rise_o, gpio.fall_o}, {m_sw, m_rise, m_fall});
            end
`ifdef GPIO_STICKY_EVENT_EN
            n_cmp++;
            if (gpio.evt_o !== m_evt) begin
                n_err++;
                $display("FAIL random_evt k=%0d got %h exp %h", k, gpio.evt_o, m_evt);
            end
`endif
        end
        clr_v = '0;
    endtask

`ifdef GPIO_STICKY_EVENT_EN
    task automatic test_sticky();
        do_reset();
        for (int k = 0; k < 12; k++) cycle(8'h02);
        n_cmp++;
        if (gpio.evt_o !== 8'h02) begin
            n_err++;
            $display("FAIL sticky_set got %h exp 02", gpio.evt_o);
        end
        for (int k = 0; k <= SS + SC; k++) begin
            clr_v = (k == SS + SC) ? 8'h02 : 8'h00;
            cycle(8'h00);
        end
        n_cmp++;
        if (gpio.evt_o !== 8'h02) begin
            n_err++;
            $display("FAIL sticky_set_wins got %h exp 02", gpio.evt_o);
        end
        clr_v = 8'h02;
        cycle(8'h00);
        clr_v = 8'h00;
        n_cmp++;
        if (gpio.evt_o !== 8'h00) begin
            n_err++;
            $display("FAIL sticky_clear got %h exp 00", gpio.evt_o);
        end
    endtask
`endif

    initial begin
        gpio.raw_i = '0;
`ifdef GPIO_STICKY_EVENT_EN
        gpio.evt_clr_i = '0;
`endif
        model_reset();
        test_reset();
        test_rise_step();
        test_glitch();
        test_multi();
        test_reset_pending();
        test_random();
`ifdef GPIO_STICKY_EVENT_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
